// File: rtl/joybus_pkg.sv
// Shared definitions for the joybus poll/command scheduler: state encoding,
// default poll words and the longest command the scheduler can send.
package joybus_pkg;

   localparam int unsigned MAX_CMD_LEN = 4;

   localparam logic [7:0]  N64_POLL      = 8'h01;
   localparam logic [23:0] GC_POLL       = 24'h400300;
   localparam logic [31:0] N64_POLL_WORD = {N64_POLL, 24'h000000};
   localparam logic [31:0] GC_POLL_WORD  = {GC_POLL, 8'h00};

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_GAP       = 2'd3
   } sched_state_e;

   // Map a requested length onto 1..MAX_CMD_LEN (0 means one byte).
   function automatic logic [2:0] clamp_len(input logic [2:0] len);
      if (len == 3'd0) begin
         return 3'd1;
      end else if (len > 3'(MAX_CMD_LEN)) begin
         return 3'(MAX_CMD_LEN);
      end else begin
         return len;
      end
   endfunction

endpackage

// File: rtl/joybus_poll_timer.sv
// Free-running poll period timer with a sticky poll request and an overrun
// pulse when the period expires while a request is still unserved.
module joybus_poll_timer #(
   parameter int unsigned PERIOD = 416667
) (
   input  logic clk,
   input  logic rst,
   input  logic take,
   output logic pend,
   output logic overrun
);

   localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap = (cnt == CW'(PERIOD - 1));

   // Period counter, pending flag (a new wrap beats a same-cycle take) and overrun pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         pend    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         cnt     <= wrap ? '0 : cnt + CW'(1);
         overrun <= wrap & pend & ~take;
         if (wrap) begin
            pend <= 1'b1;
         end else if (take) begin
            pend <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/joybus_sched.sv
// Joybus command scheduler: interleaves periodic controller polls with user
// commands, feeds the TX engine one byte at a time and reserves a response gap.
// Optional per-byte TX watchdog: define JOYBUS_SCHED_TIMEOUT_EN.
module joybus_sched
   import joybus_pkg::*;
#(
   parameter int unsigned POLL_PERIOD = 416667,
   parameter int unsigned POLL_LEN    = 1,
   parameter logic [31:0] POLL_WORD   = N64_POLL_WORD,
   parameter int unsigned RESP_GAP    = 2500,
   parameter int unsigned TX_TIMEOUT  = 4095
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        usr_valid,
   input  logic [2:0]  usr_len,
   input  logic [31:0] usr_data,
   output logic        usr_ready,
   output logic [7:0]  cmd_data,
   output logic        cmd_rdy,
   input  logic        tx_done,
   output logic        busy,
   output logic        poll_overrun
`ifdef JOYBUS_SCHED_TIMEOUT_EN
   ,
   output logic        tx_timeout
`endif
);

   localparam logic [1:0] IDLE      = ST_IDLE;
   localparam logic [1:0] LOAD      = ST_LOAD;
   localparam logic [1:0] WAIT_DONE = ST_WAIT_DONE;
   localparam logic [1:0] GAP       = ST_GAP;

   localparam int unsigned GAP_W      = (RESP_GAP > 1) ? $clog2(RESP_GAP) : 1;
   localparam logic [2:0]  POLL_LEN_C = clamp_len(3'(POLL_LEN));

   // Reject parameter sets the datapath cannot represent.
   if (POLL_LEN < 1 || POLL_LEN > MAX_CMD_LEN || RESP_GAP < 1 ||
       TX_TIMEOUT < 1 || POLL_PERIOD < 2) begin : g_cfg_err
      $error("joybus_sched: illegal parameter set");
   end

   logic [1:0]       state, state_nxt;
   logic [31:0]      cur_data, data_nxt;
   logic [2:0]       cur_len, len_nxt;
   logic [1:0]       idx, idx_nxt;
   logic [GAP_W-1:0] gap_cnt, gap_nxt;
   logic [7:0]       cmd_data_nxt;
   logic             cmd_rdy_nxt;
   logic             usr_ready_nxt;
   logic             busy_nxt;
   logic             poll_pend;
   logic             poll_take;

`ifdef JOYBUS_SCHED_TIMEOUT_EN
   localparam int unsigned TMO_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
   logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
   logic             tx_timeout_nxt;
`endif

   joybus_poll_timer #(
      .PERIOD (POLL_PERIOD)
   ) u_poll_timer (
      .clk     (clk),
      .rst     (rst),
      .take    (poll_take),
      .pend    (poll_pend),
      .overrun (poll_overrun)
   );

   // Next-state and next-output decode; cmd_data is only reloaded in LOAD so it holds through WAIT_DONE.
   always_comb begin
      state_nxt     = state;
      data_nxt      = cur_data;
      len_nxt       = cur_len;
      idx_nxt       = idx;
      gap_nxt       = gap_cnt;
      cmd_data_nxt  = cmd_data;
      cmd_rdy_nxt   = 1'b0;
      usr_ready_nxt = 1'b0;
      poll_take     = 1'b0;
`ifdef JOYBUS_SCHED_TIMEOUT_EN
      tmo_nxt        = tmo_cnt;
      tx_timeout_nxt = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (poll_pend) begin
               poll_take = 1'b1;
               data_nxt  = POLL_WORD;
               len_nxt   = POLL_LEN_C;
               idx_nxt   = 2'd0;
               state_nxt = LOAD;
            end else if (usr_valid) begin
               usr_ready_nxt = 1'b1;
               data_nxt      = usr_data;
               len_nxt       = clamp_len(usr_len);
               idx_nxt       = 2'd0;
               state_nxt     = LOAD;
            end
         end
         LOAD: begin
            cmd_data_nxt = cur_data[31:24];
            cmd_rdy_nxt  = 1'b1;
            state_nxt    = WAIT_DONE;
`ifdef JOYBUS_SCHED_TIMEOUT_EN
            tmo_nxt      = '0;
`endif
         end
         WAIT_DONE: begin
            if (tx_done) begin
               if (idx == 2'(cur_len - 3'd1)) begin
                  gap_nxt   = '0;
                  state_nxt = GAP;
               end else begin
                  idx_nxt   = idx + 2'd1;
                  data_nxt  = {cur_data[23:0], 8'h00};
                  state_nxt = LOAD;
               end
            end
`ifdef JOYBUS_SCHED_TIMEOUT_EN
            else if (tmo_cnt == TMO_W'(TX_TIMEOUT - 1)) begin
               tx_timeout_nxt = 1'b1;
               gap_nxt        = '0;
               state_nxt      = GAP;
            end else begin
               tmo_nxt = tmo_cnt + TMO_W'(1);
            end
`endif
         end
         GAP: begin
            if (gap_cnt == GAP_W'(RESP_GAP - 1)) begin
               state_nxt = IDLE;
            end else begin
               gap_nxt = gap_cnt + GAP_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur_data  <= '0;
         cur_len   <= 3'd1;
         idx       <= 2'd0;
         gap_cnt   <= '0;
         cmd_data  <= 8'h00;
         cmd_rdy   <= 1'b0;
         usr_ready <= 1'b0;
         busy      <= 1'b0;
`ifdef JOYBUS_SCHED_TIMEOUT_EN
         tmo_cnt    <= '0;
         tx_timeout <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cur_data  <= data_nxt;
         cur_len   <= len_nxt;
         idx       <= idx_nxt;
         gap_cnt   <= gap_nxt;
         cmd_data  <= cmd_data_nxt;
         cmd_rdy   <= cmd_rdy_nxt;
         usr_ready <= usr_ready_nxt;
         busy      <= busy_nxt;
`ifdef JOYBUS_SCHED_TIMEOUT_EN
         tmo_cnt    <= tmo_nxt;
         tx_timeout <= tx_timeout_nxt;
`endif
      end
   end

endmodule
